adc_spi_model: RTL and testbench
================================

ADC_SPI_MODEL -- requirements
Module: adc_spi_model

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of modelled channels (legal 1..8).
REQ-002 SHALL have parameter DATA_W, default 12, conversion width in bits (legal 8..12).
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port SS_n, input, 1, active-low slave select from the SPI master.
REQ-006 SHALL have port SCLK, input, 1, SPI clock; idles low (mode 0).
REQ-007 SHALL have port MOSI, input, 1, serial command from the master.
REQ-008 SHALL have port MISO, output, 1, serial conversion data; high-Z while SS_n high.
REQ-009 SHALL have port ch_val, input, NUM_CH*DATA_W, per-channel analog setpoints; channel k in bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port conv_cnt, output, 16, count of completed frames.
REQ-011 SHALL have port bad_ch, output, 1, one-clk pulse on a command naming channel >= NUM_CH.

Function
REQ-012 SHALL synchronise SS_n, SCLK and MOSI through two flops each, then detect SCLK rise/fall and SS_n fall/rise on clk; SCLK period SHALL be at least 8 clk.
REQ-013 SHALL run FSM IDLE -> SHIFT on synchronised SS_n fall; SHIFT -> DONE on 16th SCLK rise; DONE -> IDLE after one clk; any state -> IDLE on SS_n rise.
REQ-014 On SS_n fall, SHALL load the 16-bit response {4'h0, value, (12-DATA_W) zeros}, where value is the returned value of the current channel pointer.
REQ-015 SHALL present response MSB on MISO within 3 clk of SS_n fall; shift left one bit per SCLK fall; sample MOSI into the command register on each SCLK rise.
REQ-016 In DONE, SHALL take cmd[13:11] as the next channel; if < NUM_CH, update the channel pointer, else hold the pointer and pulse bad_ch.
REQ-017 Response is pipelined: the command in frame N selects the data returned in frame N+1.
REQ-018 In DONE, SHALL increment conv_cnt (wraps 0xFFFF -> 0x0000).
REQ-019 SS_n rise before the 16th SCLK rise SHALL abort: no pointer update, no count, no bad_ch.
REQ-020 SCLK edges while SS_n high SHALL be ignored.
REQ-021 With ADC_DROOP_EN undefined, value SHALL be the live ch_val slice of the pointed channel.

Reset
REQ-022 On rst_n low: FSM IDLE, channel pointer 0, response register 0, command register 0, conv_cnt 0, bad_ch 0, droop counters 0; MISO high-Z.
REQ-023 Reset mid-frame SHALL discard the frame; the first frame after reset returns channel 0.

Configuration
REQ-024 Macro ADC_DROOP_EN: when defined, SHALL keep one 8-bit saturating counter per channel, incremented on every second completed frame returning that channel.
REQ-025 With ADC_DROOP_EN defined, value SHALL be ch_val slice minus 16*counter, clamped at 0.
REQ-026 Without ADC_DROOP_EN, SHALL have no droop counters or subtractor.

Structure
REQ-027 Package adc_spi_pkg SHALL hold the state enum (IDLE, SHIFT, DONE), FRAME_LEN=16, CH_MSB=13, CH_LSB=11, DROOP_STEP=16.
REQ-028 Sub-module adc_spi_shifter SHALL contain the synchronisers, edge detectors and 16-bit shift registers; adc_spi_model SHALL hold the FSM, pointer, counters and value mux.

Verification
REQ-029 Reset, ch_val[0]=0xC00, frame cmd=0x2000 (ch4) -> MISO word 0x0C00, conv_cnt=1, bad_ch 0.
REQ-030 Next frame cmd=0x2800 (ch5), ch_val[4]=0x3A5 -> word 0x03A5; third frame returns ch_val[5].
REQ-031 NUM_CH=4, cmd=0x3000 (ch6) -> one-clk bad_ch pulse; next frame returns the previous channel.
REQ-032 SS_n raised after 9 SCLK rises -> conv_cnt, pointer unchanged; MISO high-Z.
REQ-033 ADC_DROOP_EN, ch_val[0]=0xC00, six frames on ch0 -> words 0xC00, 0xC00, 0xBF0, 0xBF0, 0xBE0, 0xBE0.
REQ-034 DATA_W=10, ch_val[0]=0x3FF -> word 0x0FFC.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared state encoding and frame layout constants for the SPI ADC model.
package adc_spi_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int FRAME_LEN  = 16;
  localparam int CH_MSB     = 13;
  localparam int CH_LSB     = 11;
  localparam int DROOP_STEP = 16;

  // Left-justify a conversion value into the 12-bit field under a 4-bit zero header.
  function automatic logic [FRAME_LEN-1:0] frame_word(input logic [11:0] v, input int dw);
    return {4'h0, 12'(v << (12 - dw))};
  endfunction

endpackage

// File: rtl/adc_spi_shifter.sv
// SPI front end: input synchronisers, edge detection, response and command shift registers.
module adc_spi_shifter
  import adc_spi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ss_n,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic [FRAME_LEN-1:0] load_word,
  output logic                 ss_fall,
  output logic                 ss_rise,
  output logic                 sclk_rise,
  output logic [FRAME_LEN-1:0] cmd,
  output logic                 miso_bit,
  output logic                 drive
);

  // [0],[1] are the synchroniser stages; [2] holds the previous synced value.
  logic [2:0]           ss_q;
  logic [2:0]           sclk_q;
  logic [1:0]           mosi_q;
  logic [FRAME_LEN-1:0] resp;
  logic                 sclk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q   <= 3'b111;
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      ss_q   <= {ss_q[1:0], ss_n};
      sclk_q <= {sclk_q[1:0], sclk};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign ss_fall   =  ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] &  ss_q[1];
  // SCLK activity only counts while this slave is selected.
  assign sclk_rise = drive & ~sclk_q[2] &  sclk_q[1];
  assign sclk_fall = drive &  sclk_q[2] & ~sclk_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp  <= '0;
      cmd   <= '0;
      drive <= 1'b0;
    end else begin
      if (ss_fall) begin
        resp  <= load_word;
        drive <= 1'b1;
      end else begin
        if (ss_rise)   drive <= 1'b0;
        if (sclk_fall) resp  <= {resp[FRAME_LEN-2:0], 1'b0};
      end
      if (sclk_rise) cmd <= {cmd[FRAME_LEN-2:0], mosi_q[1]};
    end
  end

  assign miso_bit = resp[FRAME_LEN-1];

endmodule

// File: rtl/adc_spi_model.sv
// Behavioural SPI ADC slave: frame FSM, pipelined channel pointer, frame counter.
// Define ADC_DROOP_EN to model per-channel droop on repeated conversions.
module adc_spi_model
  import adc_spi_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     SS_n,
  input  logic                     SCLK,
  input  logic                     MOSI,
  output wire                      MISO,
  input  logic [NUM_CH*DATA_W-1:0] ch_val,
  output logic [15:0]              conv_cnt,
  output logic                     bad_ch
);

  state_t               state;
  logic [3:0]           bit_cnt;
  logic [2:0]           ptr;
  logic [2:0]           nxt_ch;
  logic                 ss_fall, ss_rise, sclk_rise, miso_bit, drive;
  logic [FRAME_LEN-1:0] cmd, load_word;
  logic [DATA_W-1:0]    raw;
  logic [11:0]          value;
  logic                 cmd_unused;

  adc_spi_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .ss_n      (SS_n),
    .sclk      (SCLK),
    .mosi      (MOSI),
    .load_word (load_word),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .sclk_rise (sclk_rise),
    .cmd       (cmd),
    .miso_bit  (miso_bit),
    .drive     (drive)
  );

  assign MISO       = drive ? miso_bit : 1'bz;
  assign nxt_ch     = cmd[CH_MSB:CH_LSB];
  assign cmd_unused = ^{cmd[FRAME_LEN-1:CH_MSB+1], cmd[CH_LSB-1:0]};
  assign raw        = ch_val[ptr*DATA_W +: DATA_W];
  assign load_word  = frame_word(value, DATA_W);

`ifdef ADC_DROOP_EN
  // Indexed by the 3-bit channel field; entries >= NUM_CH never advance.
  logic [7:0]  droop [8];
  logic [7:0]  phase;
  logic [11:0] sub;

  always_comb begin
    sub   = 12'(droop[ptr] * DROOP_STEP);
    value = (12'(raw) > sub) ? 12'(raw) - sub : 12'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      for (int k = 0; k < 8; k++) droop[k] <= '0;
    end else if (state == DONE) begin
      phase[ptr] <= ~phase[ptr];
      if (phase[ptr] && droop[ptr] != 8'hFF) droop[ptr] <= droop[ptr] + 8'd1;
    end
  end
`else
  assign value = 12'(raw);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      ptr      <= '0;
      conv_cnt <= '0;
      bad_ch   <= 1'b0;
    end else begin
      bad_ch <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state <= IDLE;
          end else if (sclk_rise) begin
            if (bit_cnt == 4'(FRAME_LEN - 1)) state <= DONE;
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        DONE: begin
          // The full command is in; it selects the channel for the next frame.
          state    <= IDLE;
          conv_cnt <= conv_cnt + 16'd1;
          if (int'(nxt_ch) < NUM_CH) ptr <= nxt_ch;
          else                       bad_ch <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_model.sv
// Scoreboard bench: a default DUT and a NUM_CH=4/DATA_W=10 DUT share one SPI bus.
module tb_adc_spi_model;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ss_n = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic [8*12-1:0] val_a;
  logic [4*10-1:0] val_b;
  wire  miso_a, miso_b;
  logic [15:0] cnt_a, cnt_b;
  logic bad_a, bad_b;

  pullup (miso_a);
  pullup (miso_b);

  always #5 clk = ~clk;

  adc_spi_model dut_a (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi),
    .MISO(miso_a), .ch_val(val_a), .conv_cnt(cnt_a), .bad_ch(bad_a)
  );

  adc_spi_model #(.NUM_CH(4), .DATA_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi),
    .MISO(miso_b), .ch_val(val_b), .conv_cnt(cnt_b), .bad_ch(bad_b)
  );

  int chv [2][8];
  int nch [2] = '{8, 4};
  int dw  [2] = '{12, 10};
  int m_ptr [2];
  int m_cnt [2];
  int m_droop [2][8];
  int m_phase [2][8];
  int exp_q0 [$];
  int exp_q1 [$];
  int nbad_a = 0;
  int nbad_b = 0;
  int n_total = 0;
  int n_bad = 0;

  always_comb begin
    val_a = '0;
    val_b = '0;
    for (int k = 0; k < 8; k++) val_a[k*12 +: 12] = 12'(chv[0][k]);
    for (int k = 0; k < 4; k++) val_b[k*10 +: 10] = 10'(chv[1][k]);
  end

  always @(negedge clk) begin
    if (bad_a) nbad_a++;
    if (bad_b) nbad_b++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0;
      m_cnt[d] = 0;
      for (int k = 0; k < 8; k++) begin
        m_droop[d][k] = 0;
        m_phase[d][k] = 0;
      end
    end
  endtask

  function automatic int model_word(input int d);
    int v;
    v = chv[d][m_ptr[d]] & ((1 << dw[d]) - 1);
`ifdef ADC_DROOP_EN
    v = v - 16 * m_droop[d][m_ptr[d]];
    if (v < 0) v = 0;
`endif
    return v << (12 - dw[d]);
  endfunction

  task automatic model_done(input int d, input int cmdv, output int exp_bad);
    int p, nxt;
    p = m_ptr[d];
    if (m_phase[d][p] == 1 && m_droop[d][p] < 255) m_droop[d][p]++;
    m_phase[d][p] ^= 1;
    m_cnt[d] = (m_cnt[d] + 1) & 16'hFFFF;
    nxt = (cmdv >> 11) & 7;
    if (nxt < nch[d]) begin
      m_ptr[d] = nxt;
      exp_bad = 0;
    end else begin
      exp_bad = 1;
    end
  endtask

  task automatic frame(input logic [15:0] cmdv, input string tag);
    int got_a, got_b, b0a, b0b, eba, ebb;
    exp_q0.push_back(model_word(0));
    exp_q1.push_back(model_word(1));
    b0a = nbad_a;
    b0b = nbad_b;
    got_a = 0;
    got_b = 0;
    ss_n = 1'b0;
    wclk(3);
    chk({tag, "_msb_a"}, int'(miso_a), 0);
    wclk(3);
    for (int i = 15; i >= 0; i--) begin
      mosi = cmdv[i];
      wclk(5);
      got_a = (got_a << 1) | int'(miso_a);
      got_b = (got_b << 1) | int'(miso_b);
      sclk = 1'b1;
      wclk(5);
      sclk = 1'b0;
    end
    wclk(6);
    ss_n = 1'b1;
    wclk(6);
    model_done(0, int'(cmdv), eba);
    model_done(1, int'(cmdv), ebb);
    chk({tag, "_word_a"}, got_a, exp_q0.pop_front());
    chk({tag, "_word_b"}, got_b, exp_q1.pop_front());
    chk({tag, "_cnt_a"}, int'(cnt_a), m_cnt[0]);
    chk({tag, "_cnt_b"}, int'(cnt_b), m_cnt[1]);
    chk({tag, "_bad_a"}, nbad_a - b0a, eba);
    chk({tag, "_bad_b"}, nbad_b - b0b, ebb);
    chk({tag, "_hiz_a"}, int'(miso_a), 1);
  endtask

  task automatic abort_frame();
    int b0a, b0b;
    b0a = nbad_a;
    b0b = nbad_b;
    ss_n = 1'b0;
    wclk(6);
    for (int i = 0; i < 9; i++) begin
      mosi = 1'b1;
      wclk(5);
      sclk = 1'b1;
      wclk(5);
      sclk = 1'b0;
    end
    wclk(3);
    ss_n = 1'b1;
    wclk(6);
    chk("abort_cnt_a", int'(cnt_a), m_cnt[0]);
    chk("abort_cnt_b", int'(cnt_b), m_cnt[1]);
    chk("abort_bad", (nbad_a - b0a) + (nbad_b - b0b), 0);
    chk("abort_hiz_a", int'(miso_a), 1);
    chk("abort_hiz_b", int'(miso_b), 1);
  endtask

  initial begin
    chv[0] = '{12'hC00, 12'h111, 12'h2B7, 12'h333, 12'h3A5, 12'h5A7, 12'h6C1, 12'h7FE};
    chv[1] = '{10'h3FF, 10'h0AA, 10'h155, 10'h2C3, 0, 0, 0, 0};
    model_reset();
    wclk(3);
    rst_n = 1'b1;
    wclk(4);
    chk("rst_cnt_a", int'(cnt_a), 0);
    chk("rst_cnt_b", int'(cnt_b), 0);
    chk("rst_bad", nbad_a + nbad_b, 0);
    chk("rst_hiz_a", int'(miso_a), 1);
    chk("rst_hiz_b", int'(miso_b), 1);

    frame(16'h2000, "f1");
    frame(16'h2800, "f2");
    frame(16'h1000, "f3");
    frame(16'h3000, "f4");
    frame(16'h0800, "f5");

    // SCLK toggling with the slave deselected must not disturb anything.
    for (int i = 0; i < 4; i++) begin
      sclk = ~sclk;
      wclk(5);
    end
    sclk = 1'b0;

    chv[0][1] = 0;
    chv[1][1] = 0;
    abort_frame();
    chv[0][1] = 12'h123;
    chv[1][1] = 10'h2F0;
    frame(16'h0000, "f6");

    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 8; k++) chv[0][k] = $urandom_range(0, 4095);
      for (int k = 0; k < 4; k++) chv[1][k] = $urandom_range(0, 1023);
      frame(16'($urandom), "rnd");
    end

    // Reset in the middle of a frame: partial frame is dropped.
    ss_n = 1'b0;
    wclk(6);
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b1;
      wclk(5);
      sclk = 1'b0;
      wclk(5);
    end
    rst_n = 1'b0;
    wclk(2);
    ss_n = 1'b1;
    wclk(2);
    rst_n = 1'b1;
    wclk(4);
    model_reset();
    chk("mrst_cnt_a", int'(cnt_a), 0);
    chk("mrst_cnt_b", int'(cnt_b), 0);
    chk("mrst_hiz_a", int'(miso_a), 1);

    chv[0][0] = 12'hC00;
    chv[1][0] = 10'h3FF;
    for (int n = 0; n < 6; n++) frame(16'h0000, "ch0");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
